// File: rtl/pid_seq_if.sv
// Bundle of sample, control and result signals between the inertial front end,
// the PID_Math datapath and the pid_seq sequencer.
interface pid_seq_if;
    logic        vld;
    logic [15:0] ptch;
    logic [15:0] ptch_rt;
    logic        pwr_up;
    logic        rider_off;
    logic [11:0] PID_cntrl_in;
    logic [15:0] ptch_q;
    logic [15:0] ptch_rt_q;
    logic [17:0] integrator;
    logic [11:0] PID_out;
    logic        cntrl_vld;
    logic        busy;
    logic        smpl_drop;

    // Surrounding logic: drives samples and the PID_Math result, observes results.
    modport master (
        output vld, ptch, ptch_rt, pwr_up, rider_off, PID_cntrl_in,
        input  ptch_q, ptch_rt_q, integrator, PID_out, cntrl_vld, busy, smpl_drop
    );

    // Sequencer side.
    modport slave (
        input  vld, ptch, ptch_rt, pwr_up, rider_off, PID_cntrl_in,
        output ptch_q, ptch_rt_q, integrator, PID_out, cntrl_vld, busy, smpl_drop
    );
endinterface

// File: rtl/pid_seq.sv
// pid_seq: sequencer around the combinational PID_Math datapath. Latches a
// pitch sample, waits one settle cycle, then captures the clamped PID result,
// updates the decimated integrator and pulses cntrl_vld. Soft-start timer
// limits the output magnitude after power-up.
module pid_seq #(
    parameter int unsigned SS_W    = 19,
    parameter int unsigned INT_DEC = 2
) (
    input logic     clk,
    input logic     rst_n,
    pid_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MATH   = 2'd1,
        UPDATE = 2'd2
    } state_t;

    localparam logic [3:0] DEC_LAST = 4'(INT_DEC - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic              w_accept;
    logic              w_update;

    logic [15:0]       r_ptch_q;
    logic [15:0]       r_ptch_rt_q;
    logic [17:0]       r_integrator;
    logic [3:0]        r_dec_cnt;
    logic [11:0]       r_pid_out;
    logic [SS_W-1:0]   r_ss_tmr;

    logic [17:0]       w_ptch_ext;
    logic [17:0]       w_sum;
    logic              w_ovf;

    logic [10:0]       w_lim;
    logic [12:0]       w_pid_ext;
    logic [12:0]       w_lim_pos;
    logic [12:0]       w_lim_neg;
    logic [12:0]       w_clamped_ext;
    logic [11:0]       w_clamped;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and strobe decode; pwr_up low forces a return to IDLE from anywhere.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_update    = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.vld && bus.pwr_up) begin
                    w_accept    = 1'b1;
                    w_state_nxt = MATH;
                end
            end
            MATH: begin
                w_state_nxt = UPDATE;
            end
            UPDATE: begin
                w_update    = bus.pwr_up;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        if (!bus.pwr_up) begin
            w_state_nxt = IDLE;
        end
    end

    // Sample registers feeding PID_Math; they hold across a power-down abort.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ptch_q    <= '0;
            r_ptch_rt_q <= '0;
        end else if (w_accept) begin
            r_ptch_q    <= bus.ptch;
            r_ptch_rt_q <= bus.ptch_rt;
        end
    end

    // Integrator step with signed-overflow detection.
    always_comb begin
        w_ptch_ext = {{2{r_ptch_q[15]}}, r_ptch_q};
        w_sum      = r_integrator + w_ptch_ext;
        w_ovf      = (r_integrator[17] == w_ptch_ext[17]) && (w_sum[17] != r_integrator[17]);
    end

    // Decimated integrator; rider_off clears it and restarts decimation.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.pwr_up) begin
            r_integrator <= '0;
            r_dec_cnt    <= '0;
        end else if (w_update) begin
            if (bus.rider_off) begin
                r_integrator <= '0;
                r_dec_cnt    <= '0;
            end else if (r_dec_cnt == DEC_LAST) begin
                r_dec_cnt <= '0;
                if (!w_ovf) begin
                    r_integrator <= w_sum;
                end
            end else begin
                r_dec_cnt <= r_dec_cnt + 4'd1;
            end
        end
    end

    // Soft-start timer: counts while powered, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.pwr_up) begin
            r_ss_tmr <= '0;
        end else if (r_ss_tmr != '1) begin
            r_ss_tmr <= r_ss_tmr + 1'b1;
        end
    end

    // Symmetric magnitude clamp in 13-bit signed so -lim never wraps.
    always_comb begin
        w_lim     = r_ss_tmr[SS_W-1 -: 11];
        w_pid_ext = {bus.PID_cntrl_in[11], bus.PID_cntrl_in};
        w_lim_pos = {2'b00, w_lim};
        w_lim_neg = 13'd0 - w_lim_pos;
        if ($signed(w_pid_ext) > $signed(w_lim_pos)) begin
            w_clamped_ext = w_lim_pos;
        end else if ($signed(w_pid_ext) < $signed(w_lim_neg)) begin
            w_clamped_ext = w_lim_neg;
        end else begin
            w_clamped_ext = w_pid_ext;
        end
        w_clamped = w_clamped_ext[11:0];
    end

    // Output control word, captured in UPDATE.
    always_ff @(posedge clk) begin
        if (!rst_n || !bus.pwr_up) begin
            r_pid_out <= '0;
        end else if (w_update) begin
            r_pid_out <= w_clamped;
        end
    end

    assign bus.ptch_q     = r_ptch_q;
    assign bus.ptch_rt_q  = r_ptch_rt_q;
    assign bus.integrator = r_integrator;
    assign bus.PID_out    = r_pid_out;
    assign bus.cntrl_vld  = w_update;
    assign bus.busy       = (r_state != IDLE);
    assign bus.smpl_drop  = bus.vld && (r_state != IDLE);

endmodule

// File: tb/tb_pid_seq.sv
// Scoreboard bench for pid_seq: stimulus pushes expected {PID_out, integrator}
// per accepted sample; a monitor pops and compares after every cntrl_vld.
module tb_pid_seq;

    typedef struct packed {
        logic [11:0] pid;
        logic [17:0] intg;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    exp_t sb[$];
    exp_t m_e;

    pid_seq_if bus();

    pid_seq #(.SS_W(11), .INT_DEC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string n, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, act, req);
        end
    endtask

    // Monitor: compare result registers the cycle after each cntrl_vld.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && bus.cntrl_vld === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_cntrl_vld actual=1 required=0");
            end else begin
                m_e = sb.pop_front();
                @(posedge clk);
                #1;
                check("PID_out", {20'd0, bus.PID_out}, {20'd0, m_e.pid});
                check("integrator", {14'd0, bus.integrator}, {14'd0, m_e.intg});
            end
        end
    end

    // One accepted sample; called #1 after an edge with the DUT idle.
    task automatic send(input logic [15:0] p, input logic [11:0] c, input logic ro,
                        input logic [11:0] ep, input logic [17:0] ei);
        exp_t e;
        e.pid  = ep;
        e.intg = ei;
        bus.ptch         = p;
        bus.ptch_rt      = p ^ 16'hA5A5;
        bus.PID_cntrl_in = c;
        bus.rider_off    = ro;
        bus.vld          = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1;
        bus.vld = 1'b0;
        check("ptch_q", {16'd0, bus.ptch_q}, {16'd0, p});
        check("ptch_rt_q", {16'd0, bus.ptch_rt_q}, {16'd0, p ^ 16'hA5A5});
        check("busy_math", {31'd0, bus.busy}, 32'd1);
        check("cntrl_vld_early", {31'd0, bus.cntrl_vld}, 32'd0);
        @(posedge clk);
        #1;
        check("cntrl_vld_latency", {31'd0, bus.cntrl_vld}, 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic pwr_cycle();
        bus.pwr_up = 1'b0;
        @(posedge clk);
        #1;
        bus.pwr_up = 1'b1;
    endtask

    // Power up for exactly enough edges that lim = 256 at the UPDATE edge.
    task automatic ss_run(input logic [11:0] c, input logic [11:0] ep);
        bus.pwr_up = 1'b1;
        repeat (254) @(posedge clk);
        #1;
        send(16'h0000, c, 1'b0, ep, 18'h0);
        bus.pwr_up = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n            = 1'b0;
        bus.vld          = 1'b1;
        bus.pwr_up       = 1'b1;
        bus.ptch         = 16'h1234;
        bus.ptch_rt      = 16'h5678;
        bus.rider_off    = 1'b0;
        bus.PID_cntrl_in = 12'h000;

        // Reset with vld/pwr_up asserted.
        @(posedge clk);
        #1;
        check("rst_ptch_q", {16'd0, bus.ptch_q}, 32'd0);
        check("rst_ptch_rt_q", {16'd0, bus.ptch_rt_q}, 32'd0);
        check("rst_integrator", {14'd0, bus.integrator}, 32'd0);
        check("rst_PID_out", {20'd0, bus.PID_out}, 32'd0);
        check("rst_cntrl_vld", {31'd0, bus.cntrl_vld}, 32'd0);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_smpl_drop", {31'd0, bus.smpl_drop}, 32'd0);
        bus.vld = 1'b0;
        rst_n   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_ptch_q", {16'd0, bus.ptch_q}, 32'd0);

        // Let soft start saturate (lim = 2047).
        repeat (2100) @(posedge clk);
        #1;
        send(16'h0010, 12'h123, 1'b0, 12'h123, 18'h0);
        send(16'h0000, 12'h800, 1'b0, 12'h801, 18'h0);
        send(16'h0000, 12'h7FF, 1'b0, 12'h7FF, 18'h0);
        send(16'h0000, 12'hE00, 1'b0, 12'hE00, 18'h0);

        // Second vld during MATH is dropped.
        begin
            exp_t e;
            e.pid  = 12'h055;
            e.intg = 18'h0;
            bus.ptch         = 16'h0000;
            bus.ptch_rt      = 16'h0000;
            bus.PID_cntrl_in = 12'h055;
            bus.vld          = 1'b1;
            sb.push_back(e);
            @(posedge clk);
            #1;
            bus.ptch = 16'h7777;
            @(negedge clk);
            check("smpl_drop", {31'd0, bus.smpl_drop}, 32'd1);
            check("drop_no_cntrl_vld", {31'd0, bus.cntrl_vld}, 32'd0);
            @(posedge clk);
            #1;
            bus.vld = 1'b0;
            check("drop_ptch_q", {16'd0, bus.ptch_q}, 32'd0);
            check("drop_busy_update", {31'd0, bus.busy}, 32'd1);
            @(posedge clk);
            #1;
        end

        // Abort with pwr_up low during MATH.
        bus.ptch         = 16'h0100;
        bus.PID_cntrl_in = 12'h321;
        bus.vld          = 1'b1;
        @(posedge clk);
        #1;
        bus.vld = 1'b0;
        check("abort_busy_math", {31'd0, bus.busy}, 32'd1);
        bus.pwr_up = 1'b0;
        @(posedge clk);
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_integrator", {14'd0, bus.integrator}, 32'd0);
        check("abort_PID_out", {20'd0, bus.PID_out}, 32'd0);
        check("abort_ptch_q_hold", {16'd0, bus.ptch_q}, 32'h0100);
        // vld while unpowered is ignored without a drop pulse.
        bus.ptch = 16'h0200;
        bus.vld  = 1'b1;
        @(negedge clk);
        check("nopwr_smpl_drop", {31'd0, bus.smpl_drop}, 32'd0);
        @(posedge clk);
        #1;
        bus.vld = 1'b0;
        check("nopwr_busy", {31'd0, bus.busy}, 32'd0);
        check("nopwr_ptch_q", {16'd0, bus.ptch_q}, 32'h0100);
        @(posedge clk);
        #1;

        // Soft-start clamp at lim = 256.
        ss_run(12'h7FF, 12'h100);
        ss_run(12'h800, 12'hF00);
        ss_run(12'h100, 12'h100);
        ss_run(12'hF00, 12'hF00);

        // Decimated accumulation.
        bus.pwr_up = 1'b1;
        @(posedge clk);
        #1;
        send(16'h0040, 12'h000, 1'b0, 12'h000, 18'h00000);
        send(16'h0040, 12'h000, 1'b0, 12'h000, 18'h00040);
        send(16'h0040, 12'h000, 1'b0, 12'h000, 18'h00040);
        send(16'h0040, 12'h000, 1'b0, 12'h000, 18'h00080);

        // Positive overflow: build 0x1FFFF then add 1.
        pwr_cycle();
        send(16'h7FFF, 12'h000, 1'b0, 12'h000, 18'h00000);
        send(16'h7FFF, 12'h000, 1'b0, 12'h000, 18'h07FFF);
        send(16'h7FFF, 12'h000, 1'b0, 12'h000, 18'h07FFF);
        send(16'h7FFF, 12'h000, 1'b0, 12'h000, 18'h0FFFE);
        send(16'h7FFF, 12'h000, 1'b0, 12'h000, 18'h0FFFE);
        send(16'h7FFF, 12'h000, 1'b0, 12'h000, 18'h17FFD);
        send(16'h7FFF, 12'h000, 1'b0, 12'h000, 18'h17FFD);
        send(16'h7FFF, 12'h000, 1'b0, 12'h000, 18'h1FFFC);
        send(16'h0003, 12'h000, 1'b0, 12'h000, 18'h1FFFC);
        send(16'h0003, 12'h000, 1'b0, 12'h000, 18'h1FFFF);
        send(16'h0001, 12'h000, 1'b0, 12'h000, 18'h1FFFF);
        send(16'h0001, 12'h000, 1'b0, 12'h000, 18'h1FFFF);

        // rider_off clears integrator and decimation count.
        pwr_cycle();
        send(16'hC000, 12'h000, 1'b0, 12'h000, 18'h00000);
        send(16'hC000, 12'h000, 1'b0, 12'h000, 18'h3C000);
        send(16'h0010, 12'h000, 1'b0, 12'h000, 18'h3C000);
        send(16'h0010, 12'h000, 1'b1, 12'h000, 18'h00000);
        send(16'h0020, 12'h000, 1'b0, 12'h000, 18'h00000);
        send(16'h0020, 12'h000, 1'b0, 12'h000, 18'h00020);

        repeat (4) @(posedge clk);
        #1;
        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
